packet_splitter: RTL and testbench

- Transmit-side counterpart of the UART packet receiver in the Sigma Delta DAQ.
- Accepts one MESSAGE_LENGTH-bit message over a valid/ready handshake and computes CRC-8 over its bytes.
- Serialises the message as SEGMENT_COUNT UART frames (message bytes, then CRC byte) on a single serial line.
- Byte order, CRC and framing exactly match what the receive-side packet merger expects.

---
 rtl/packet_splitter.sv | 154 +++++++++++++++
 tb/tb_packet_splitter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_splitter.sv
// UART packet transmitter: sends a message as byte frames plus a CRC-8 byte.
// Ports: clk, reset, i_data/i_valid in, o_ready, o_serial_out, o_done out.
module packet_splitter #(
    parameter int DATA_LENGTH         = 8,
    parameter int MESSAGE_LENGTH      = 48,
    parameter int CRC_LENGTH          = 8,
    parameter int TRANSMISSION_LENGTH = MESSAGE_LENGTH + CRC_LENGTH,
    parameter int SEGMENT_COUNT       = TRANSMISSION_LENGTH / DATA_LENGTH,
    parameter int CLKS_PER_BIT        = 868,
    parameter logic [CRC_LENGTH-1:0] CRC_POLY = 8'h07
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MESSAGE_LENGTH-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_serial_out,
    output logic                      o_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int SEG_W  = $clog2(SEGMENT_COUNT);
    localparam int BIT_W  = $clog2(DATA_LENGTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(SEGMENT_COUNT - 1);
    localparam logic [SEG_W-1:0]  SEG_PRE   = SEG_W'(SEGMENT_COUNT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                    state, state_d;
    logic [BAUD_W-1:0]         baud_cnt, baud_d;
    logic [BIT_W-1:0]          bit_cnt, bit_d;
    logic [SEG_W-1:0]          seg_idx, seg_d;
    logic [DATA_LENGTH-1:0]    shift_q, shift_d;
    logic [MESSAGE_LENGTH-1:0] msg_q, msg_d;
    logic [CRC_LENGTH-1:0]     crc_q, crc_d, crc_next;
    logic                      serial_d, ready_d, done_d;
    logic                      accept, bit_end;

    // MSB-first CRC update over one byte
    function automatic logic [CRC_LENGTH-1:0] crc_byte(
        input logic [CRC_LENGTH-1:0]  c,
        input logic [DATA_LENGTH-1:0] b
    );
        logic [CRC_LENGTH-1:0] r;
        r = c ^ CRC_LENGTH'(b);
        for (int i = 0; i < DATA_LENGTH; i++) begin
            r = r[CRC_LENGTH-1] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

    assign accept  = i_valid && o_ready;
    assign bit_end = (baud_cnt == BAUD_LAST);

    // The message register shifts down one byte per segment, so its low
    // byte is always the byte that just finished; CRC folds it in there.
    assign crc_next = crc_byte(crc_q, msg_q[DATA_LENGTH-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            seg_idx      <= '0;
            shift_q      <= '0;
            msg_q        <= '0;
            crc_q        <= '0;
            o_ready      <= 1'b1;
            o_serial_out <= 1'b1;
            o_done       <= 1'b0;
        end else begin
            state        <= state_d;
            baud_cnt     <= baud_d;
            bit_cnt      <= bit_d;
            seg_idx      <= seg_d;
            shift_q      <= shift_d;
            msg_q        <= msg_d;
            crc_q        <= crc_d;
            o_ready      <= ready_d;
            o_serial_out <= serial_d;
            o_done       <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        seg_d   = seg_idx;
        shift_d = shift_q;
        msg_d   = msg_q;
        crc_d   = crc_q;
        if (state != IDLE) begin
            baud_d = bit_end ? '0 : baud_cnt + 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    msg_d   = i_data;
                    shift_d = i_data[DATA_LENGTH-1:0];
                    crc_d   = '0;
                    seg_d   = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (seg_idx == SEG_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = START;
                        seg_d   = seg_idx + 1'b1;
                        crc_d   = crc_next;
                        msg_d   = msg_q >> DATA_LENGTH;
                        shift_d = (seg_idx == SEG_PRE)
                                ? DATA_LENGTH'(crc_next)
                                : msg_q[2*DATA_LENGTH-1:DATA_LENGTH];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step
    always_comb begin
        ready_d = (state_d == IDLE);
        done_d  = (state == STOP) && (state_d == IDLE);
        unique case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_packet_splitter.sv
// Self-checking bench for packet_splitter with a fast baud rate.
// Reference: bitstream CRC by long division and an ideal UART waveform.
module tb_packet_splitter;

    localparam int CPB  = 4;
    localparam int PKT  = 70 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_serial_out;
    logic        o_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic       cap_line [0:599];
    logic       cap_done [0:599];
    logic       cap_ready[0:599];
    logic       exp_line [0:PKT-1];
    logic [7:0] exp_bytes[7];
    logic [7:0] got_bytes[7];

    packet_splitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_serial_out (o_serial_out),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // CRC as remainder of (message bits * x^8) mod x^8+x^2+x+1,
    // bytes in transmit order, each byte MSB first.
    function automatic logic [7:0] model_crc(input logic [47:0] m);
        logic [55:0] s;
        s = '0;
        for (int k = 0; k < 6; k++) s[55-8*k -: 8] = m[8*k +: 8];
        for (int i = 55; i >= 8; i--) begin
            if (s[i]) s[i -: 9] = s[i -: 9] ^ 9'h107;
        end
        return s[7:0];
    endfunction

    task automatic build_expected(input logic [47:0] m);
        logic v;
        for (int k = 0; k < 6; k++) exp_bytes[k] = m[8*k +: 8];
        exp_bytes[6] = model_crc(m);
        for (int k = 0; k < 7; k++) begin
            for (int p = 0; p < 10; p++) begin
                if (p == 0) v = 1'b0;
                else if (p == 9) v = 1'b1;
                else v = exp_bytes[k][p-1];
                for (int c = 0; c < CPB; c++) exp_line[(k*10+p)*CPB+c] = v;
            end
        end
    endtask

    task automatic launch(input logic [47:0] m);
        @(negedge clk);
        i_data  = m;
        i_valid = 1'b1;
    endtask

    // Samples once per cycle starting the cycle after the acceptance edge
    task automatic capture(input int n, input bit hold,
                           input logic [47:0] next_m);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_line[i]  = o_serial_out;
            cap_done[i]  = o_done;
            cap_ready[i] = o_ready;
            if (hold) begin
                i_data = (i >= n - 2) ? next_m
                                      : 48'({$urandom(), $urandom()});
            end else begin
                i_valid = 1'b0;
            end
        end
    endtask

    // Receiver: sample the middle of every data bit
    task automatic decode();
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 8; j++) begin
                got_bytes[k][j] = cap_line[k*10*CPB + (j+1)*CPB + CPB/2];
            end
        end
    endtask

    function automatic int wave_errs();
        int e = 0;
        for (int i = 0; i < PKT; i++) if (cap_line[i] !== exp_line[i]) e++;
        return e;
    endfunction

    function automatic int done_count(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_done[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < PKT; i++) if (cap_ready[i] === 1'b0) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_serial_out, o_ready, o_done} !== 3'b110) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %b required 110", i,
                         {o_serial_out, o_ready, o_done});
            end
        end
    endtask

    task automatic test_zero();
        int e;
        build_expected(48'h0);
        launch(48'h0);
        capture(PKT + 2, 1'b0, 48'h0);
        e = wave_errs();
        n_checks++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL zero_wave: %0d bad cycles required 0", e);
        end
        decode();
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (got_bytes[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL zero_byte%0d: got %h required 00", k,
                         got_bytes[k]);
            end
        end
        n_checks++;
        if (done_count(PKT + 2) !== 1 || cap_done[PKT] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: count %0d at_end %b required 1 1",
                     done_count(PKT + 2), cap_done[PKT]);
        end
        n_checks++;
        if (busy_count() !== PKT || cap_ready[PKT] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: busy %0d end %b required %0d 1",
                     busy_count(), cap_ready[PKT], PKT);
        end
    endtask

    task automatic test_one();
        int e;
        build_expected(48'h1);
        launch(48'h1);
        capture(PKT + 2, 1'b0, 48'h0);
        e = wave_errs();
        n_checks++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL one_wave: %0d bad cycles required 0", e);
        end
        decode();
        n_checks++;
        if (got_bytes[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL one_byte0: got %h required 01", got_bytes[0]);
        end
        n_checks++;
        if (got_bytes[6] !== 8'h29) begin
            n_fail++;
            $display("FAIL one_crc: got %h required 29", got_bytes[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] m1, m2;
        int e;
        m1 = 48'({$urandom(), $urandom()});
        m2 = 48'({$urandom(), $urandom()});
        build_expected(m1);
        launch(m1);
        capture(PKT + 1, 1'b1, m2);
        e = wave_errs();
        n_checks++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL b2b_first: %0d bad cycles required 0", e);
        end
        n_checks++;
        if (cap_line[PKT] !== 1'b1 || cap_ready[PKT] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: line %b ready %b required 1 1",
                     cap_line[PKT], cap_ready[PKT]);
        end
        build_expected(m2);
        capture(PKT + 2, 1'b0, 48'h0);
        e = wave_errs();
        n_checks++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: %0d bad cycles required 0", e);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] m;
        int e;
        m = 48'({$urandom(), $urandom()}) & ~(48'hFF << 24);
        launch(m);
        capture(130, 1'b0, 48'h0);
        n_checks++;
        if (cap_line[129] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: line %b required 0", cap_line[129]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({o_serial_out, o_ready, o_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_async: got %b required 110",
                     {o_serial_out, o_ready, o_done});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_serial_out, o_ready, o_done} !== 3'b110) begin
                n_fail++;
                $display("FAIL mid_idle[%0d]: got %b required 110", i,
                         {o_serial_out, o_ready, o_done});
            end
        end
        m = 48'({$urandom(), $urandom()});
        build_expected(m);
        launch(m);
        capture(PKT + 2, 1'b0, 48'h0);
        e = wave_errs();
        n_checks++;
        if (e !== 0 || done_count(PKT + 2) !== 1) begin
            n_fail++;
            $display("FAIL mid_after: bad %0d done %0d required 0 1", e,
                     done_count(PKT + 2));
        end
    endtask

    task automatic test_random();
        logic [47:0] m;
        int e;
        for (int r = 0; r < 4; r++) begin
            m = 48'({$urandom(), $urandom()});
            build_expected(m);
            launch(m);
            capture(PKT + 2, 1'b0, 48'h0);
            e = wave_errs();
            n_checks++;
            if (e !== 0 || done_count(PKT + 2) !== 1) begin
                n_fail++;
                $display("FAIL rand%0d %h: bad %0d done %0d required 0 1",
                         r, m, e, done_count(PKT + 2));
            end
        end
    endtask

    task automatic test_loopback();
        logic [47:0] m, rx;
        m = 48'hA5A5_1234_BEEF;
        launch(m);
        capture(PKT + 2, 1'b0, 48'h0);
        decode();
        rx = {got_bytes[5], got_bytes[4], got_bytes[3],
              got_bytes[2], got_bytes[1], got_bytes[0]};
        n_checks++;
        if (rx !== m) begin
            n_fail++;
            $display("FAIL loop_msg: got %h required %h", rx, m);
        end
        n_checks++;
        if (got_bytes[6] !== model_crc(rx)) begin
            n_fail++;
            $display("FAIL loop_crc: got %h required %h", got_bytes[6],
                     model_crc(rx));
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_one();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
